// File: rtl/seg_scan_ctrl.sv
// Purpose: 4-digit BCD tick counter with multiplexed active-low 7-segment display scan.
// Latency: t->t_s 2 cycles; count/idx change -> an/seg 1 cycle; tick -> clock toggle 1 cycle.
// Backpressure: none; free-running outputs. Optional SEG_BLANK_EN enables leading-zero blanking.
module seg_scan_ctrl #(
    parameter int TICK_DIV = 20000000,
    parameter int SCAN_DIV = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        t,
    input  logic        clr,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        clock,
    output logic [15:0] count
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [SW-1:0] scan;
    logic [1:0]    idx;
    logic          t_m;
    logic          t_s;
    logic          tick;
    logic [15:0]   count_inc;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_nxt;

    assign tick = (presc == PRESC_LAST);

    // Prescaler, tick-driven square wave and t synchronizer; clr deliberately not involved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            clock <= 1'b0;
            t_m   <= 1'b0;
            t_s   <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            clock <= clock ^ tick;
            t_m   <= t;
            t_s   <= t_m;
        end
    end

    // Scan counter stepping the displayed digit index at each wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan <= '0;
            idx  <= 2'd0;
        end else if (scan == SCAN_LAST) begin
            scan <= '0;
            idx  <= idx + 2'd1;
        end else begin
            scan <= scan + 1'b1;
        end
    end

    // Ripple BCD increment: every digit that is 9 with an incoming carry rolls to 0.
    always_comb begin
        logic carry;
        count_inc = count;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count[i*4 +: 4] >= 4'd9) begin
                    count_inc[i*4 +: 4] = 4'd0;
                end else begin
                    count_inc[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // BCD count register; clr wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (clr) begin
            count <= 16'h0000;
        end else if (tick && t_s) begin
            count <= count_inc;
        end
    end

    // Select the digit under scan and decide whether it is a leading zero.
    always_comb begin
        digit = 4'd0;
        blank = 1'b0;
        case (idx)
            2'd0: begin
                digit = count[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                digit = count[7:4];
                blank = (count[15:4] == 12'd0);
            end
            2'd2: begin
                digit = count[11:8];
                blank = (count[15:8] == 8'd0);
            end
            default: begin
                digit = count[15:12];
                blank = (count[15:12] == 4'd0);
            end
        endcase
    end

    // Active-low segment decode (bit 6 = a .. bit 0 = g); non-decimal nibbles go dark.
    always_comb begin
        seg_nxt = 7'b1111111;
        case (digit)
            4'd0: seg_nxt = 7'b0000001;
            4'd1: seg_nxt = 7'b1001111;
            4'd2: seg_nxt = 7'b0010010;
            4'd3: seg_nxt = 7'b0000110;
            4'd4: seg_nxt = 7'b1001100;
            4'd5: seg_nxt = 7'b0100100;
            4'd6: seg_nxt = 7'b0100000;
            4'd7: seg_nxt = 7'b0001111;
            4'd8: seg_nxt = 7'b0000000;
            4'd9: seg_nxt = 7'b0000100;
            default: seg_nxt = 7'b1111111;
        endcase
`ifdef SEG_BLANK_EN
        if (blank) begin
            seg_nxt = 7'b1111111;
        end
`endif
    end

    // Display registers sampled from the current idx/count, so a digit is never torn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_nxt;
        end
    end

`ifndef SEG_BLANK_EN
    // Blanking decision only matters when leading-zero suppression is built in.
    logic unused_blank;
    assign unused_blank = blank;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Purpose: randomized scoreboard bench for seg_scan_ctrl against a decimal-arithmetic model.
// Latency: expectations are queued at the falling edge and checked 1 time unit after the rising edge.
// Backpressure: none; every rising edge produces one set of outputs to compare.
module tb_seg_scan_ctrl;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic        clk;
    logic        rst_n;
    logic        t;
    logic        clr;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        clock;
    logic [15:0] count;

    seg_scan_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (t),
        .clr   (clr),
        .seg   (seg),
        .an    (an),
        .clock (clock),
        .count (count)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  an;
        logic        clock;
        logic [15:0] count;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: edges since reset, decimal count, tick parity, t history.
    int     m_k;
    int     m_cnt;
    logic   m_clock;
    logic   m_t1;
    logic   m_t2;

    logic [6:0] enc_tab [10];
    int         p10 [4];

    initial begin
        enc_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        p10 = '{1, 10, 100, 1000};
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((v / p10[i]) % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Apply one cycle of inputs and queue what the outputs must be after the next rising edge.
    task automatic step(input logic r, input logic tv, input logic cv);
        exp_t x;
        int   id;
        int   dg;
        bit   tk;
        rst_n = r;
        t     = tv;
        clr   = cv;
        if (!r) begin
            m_k = 0; m_cnt = 0; m_clock = 1'b0; m_t1 = 1'b0; m_t2 = 1'b0;
            x.an  = 4'b1111;
            x.seg = 7'b1111111;
        end else begin
            id    = (m_k / SCAN_DIV) % 4;
            dg    = (m_cnt / p10[id]) % 10;
            x.an  = ~(4'b0001 << id);
            x.seg = enc_tab[dg];
`ifdef SEG_BLANK_EN
            if (id > 0 && m_cnt < p10[id]) x.seg = 7'b1111111;
`endif
            tk = ((m_k % TICK_DIV) == TICK_DIV - 1);
            if (cv) m_cnt = 0;
            else if (tk && m_t2) m_cnt = (m_cnt + 1) % 10000;
            if (tk) m_clock = ~m_clock;
            m_t2 = m_t1;
            m_t1 = tv;
            m_k++;
        end
        x.clock = m_clock;
        x.count = to_bcd(m_cnt);
        exp_q.push_back(x);
    endtask

    // Monitor: pop the oldest expectation and compare once outputs have settled.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an",    16'(an),    16'(e.an));
            check("seg",   16'(seg),   16'(e.seg));
            check("clock", 16'(clock), 16'(e.clock));
            check("count", count,      e.count);
        end
    end

    initial begin
        logic r, tv, cv;
        rst_n = 1'b0; t = 1'b0; clr = 1'b0;
        m_k = 0; m_cnt = 0; m_clock = 1'b0; m_t1 = 1'b0; m_t2 = 1'b0;

        // Reset, then idle with t low: count holds, clock and scan keep running.
        @(negedge clk); step(1'b0, 1'b0, 1'b0);
        @(negedge clk); step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); step(1'b1, 1'b0, 1'b0);
        end

        // Random mix of enable levels, clears and short resets.
        tv = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) tv = ~tv;
            r  = ($urandom_range(0, 249) != 0);
            cv = ($urandom_range(0, 59) == 0);
            @(negedge clk); step(r, tv, cv);
        end

        // Long enabled run from zero through 0999->1000 and 9999->0000.
        @(negedge clk); step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40200; i++) begin
            @(negedge clk); step(1'b1, 1'b1, 1'b0);
        end

        // Clears scattered across prescaler phases, then a reset mid-scan.
        for (int i = 0; i < 200; i++) begin
            cv = ($urandom_range(0, 9) == 0);
            @(negedge clk); step(1'b1, 1'b1, cv);
        end
        @(negedge clk); step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); step(1'b1, 1'b1, 1'b0);
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
